// File: rtl/p405s_icu_vawrctl_if.sv
// Request/strobe bundle between ICU requesters and the valid-bit write controller.
// The master drives requests and the lookup index; the slave is the controller.
interface p405s_icu_vawrctl_if;
  logic       fill_done_req;
  logic [1:3] fill_done_index;
  logic       fill_done_ack;
  logic       inv_req;
  logic [1:3] inv_index;
  logic       inv_ack;
  logic       flash_req;
  logic       flash_ack;
  logic       va_wr_cycle;
  logic [1:3] va_wr_index;
  logic       va_wr_data;
  logic       wr_flash;
  logic [0:7] valid_vec;
  logic [1:3] lkup_index;
  logic       lkup_valid;
  logic       busy;

  modport master (
    output fill_done_req, fill_done_index, inv_req, inv_index, flash_req, lkup_index,
    input  fill_done_ack, inv_ack, flash_ack, va_wr_cycle, va_wr_index, va_wr_data,
           wr_flash, valid_vec, lkup_valid, busy
  );

  modport slave (
    input  fill_done_req, fill_done_index, inv_req, inv_index, flash_req, lkup_index,
    output fill_done_ack, inv_ack, flash_ack, va_wr_cycle, va_wr_index, va_wr_data,
           wr_flash, valid_vec, lkup_valid, busy
  );
endinterface

// File: rtl/p405s_icu_vawrctl.sv
// ICU valid-bit array write controller: arbitrates flash > invalidate > fill, issues registered
// write strobes and keeps a shadow copy of the 8 valid bits for lookup.
module p405s_icu_vawrctl #(
  parameter int unsigned FlashCycles = 2  // legal range 1..7
) (
  input  logic                  cb_i,
  input  logic                  reset_i,
  p405s_icu_vawrctl_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StWrite, StFlash} state_e;

  localparam logic [2:0] FlashLoad = 3'(FlashCycles - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_cycle_q, wr_cycle_d;
  logic [1:3] wr_index_q, wr_index_d;
  logic       wr_data_q, wr_data_d;
  logic       wr_flash_q, wr_flash_d;
  logic       fill_ack_q, fill_ack_d;
  logic       inv_ack_q, inv_ack_d;
  logic       flash_ack_q, flash_ack_d;
  logic       busy_q, busy_d;
  logic [0:7] valid_q, valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_cycle_d  = 1'b0;
    wr_index_d  = 3'b000;
    wr_data_d   = 1'b0;
    wr_flash_d  = 1'b0;
    fill_ack_d  = 1'b0;
    inv_ack_d   = 1'b0;
    flash_ack_d = 1'b0;
    valid_d     = valid_q;

    unique case (state_q)
      StIdle: begin
        if (bus.flash_req) begin
          // Shadow bits clear on entry so lookups read invalid from the first flash cycle.
          state_d     = StFlash;
          cnt_d       = FlashLoad;
          wr_flash_d  = 1'b1;
          flash_ack_d = 1'b1;
          valid_d     = 8'h00;
        end else if (bus.inv_req) begin
          state_d    = StWrite;
          wr_cycle_d = 1'b1;
          wr_index_d = bus.inv_index;
          wr_data_d  = 1'b0;
          inv_ack_d  = 1'b1;
        end else if (bus.fill_done_req) begin
          state_d    = StWrite;
          wr_cycle_d = 1'b1;
          wr_index_d = bus.fill_done_index;
          wr_data_d  = 1'b1;
          fill_ack_d = 1'b1;
        end
      end
      StWrite: begin
        // Always pass back through idle; no write suppression on an unchanged bit.
        valid_d[wr_index_q] = wr_data_q;
        state_d             = StIdle;
      end
      StFlash: begin
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d      = cnt_q - 3'd1;
          wr_flash_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge cb_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      wr_cycle_q  <= 1'b0;
      wr_index_q  <= 3'b000;
      wr_data_q   <= 1'b0;
      wr_flash_q  <= 1'b0;
      fill_ack_q  <= 1'b0;
      inv_ack_q   <= 1'b0;
      flash_ack_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_cycle_q  <= wr_cycle_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      wr_flash_q  <= wr_flash_d;
      fill_ack_q  <= fill_ack_d;
      inv_ack_q   <= inv_ack_d;
      flash_ack_q <= flash_ack_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.fill_done_ack = fill_ack_q;
  assign bus.inv_ack       = inv_ack_q;
  assign bus.flash_ack     = flash_ack_q;
  assign bus.va_wr_cycle   = wr_cycle_q;
  assign bus.va_wr_index   = wr_index_q;
  assign bus.va_wr_data    = wr_data_q;
  assign bus.wr_flash      = wr_flash_q;
  assign bus.busy          = busy_q;
  assign bus.valid_vec     = valid_q;
  assign bus.lkup_valid    = valid_q[bus.lkup_index];

endmodule

// File: tb/tb_p405s_icu_vawrctl.sv
// Directed table-driven bench for the valid-bit write controller; two instances cover
// flash lengths of 3 and 4 cycles.
module tb_p405s_icu_vawrctl;

  logic cb;
  logic rst_a, rst_b;

  p405s_icu_vawrctl_if a_if ();
  p405s_icu_vawrctl_if b_if ();

  p405s_icu_vawrctl #(.FlashCycles(3)) dut_a (.cb_i(cb), .reset_i(rst_a), .bus(a_if));
  p405s_icu_vawrctl #(.FlashCycles(4)) dut_b (.cb_i(cb), .reset_i(rst_b), .bus(b_if));

  initial cb = 1'b0;
  always #5 cb = ~cb;

  // {fill_ack, inv_ack, flash_ack, wr_cycle, wr_index, wr_data, wr_flash, busy, valid, lkup}
  logic [18:0] obs_a, obs_b;
  assign obs_a = {a_if.fill_done_ack, a_if.inv_ack, a_if.flash_ack, a_if.va_wr_cycle,
                  a_if.va_wr_index, a_if.va_wr_data, a_if.wr_flash, a_if.busy,
                  a_if.valid_vec, a_if.lkup_valid};
  assign obs_b = {b_if.fill_done_ack, b_if.inv_ack, b_if.flash_ack, b_if.va_wr_cycle,
                  b_if.va_wr_index, b_if.va_wr_data, b_if.wr_flash, b_if.busy,
                  b_if.valid_vec, b_if.lkup_valid};

  typedef struct {
    string       name;
    logic        fr;
    logic [2:0]  fi;
    logic        ir;
    logic [2:0]  ii;
    logic        xr;
    logic [2:0]  lk;
    logic [18:0] exp;
  } vec_t;

  vec_t vq[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  function automatic logic [18:0] mk(logic fa, logic ia, logic xa, logic wc, logic [2:0] wi,
                                     logic wd, logic wf, logic bsy, logic [7:0] vv, logic lv);
    return {fa, ia, xa, wc, wi, wd, wf, bsy, vv, lv};
  endfunction

  task automatic add(string n, logic fr, logic [2:0] fi, logic ir, logic [2:0] ii, logic xr,
                     logic [2:0] lk, logic [18:0] e);
    vec_t v;
    v.name = n; v.fr = fr; v.fi = fi; v.ir = ir; v.ii = ii; v.xr = xr; v.lk = lk; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic check(string n, logic [18:0] act, logic [18:0] e);
    total_cnt++;
    if (act === e) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, e);
  endtask

  task automatic tick();
    @(posedge cb);
    #1;
  endtask

  task automatic run_vecs(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      a_if.fill_done_req   = vq[i].fr;
      a_if.fill_done_index = vq[i].fi;
      a_if.inv_req         = vq[i].ir;
      a_if.inv_index       = vq[i].ii;
      a_if.flash_req       = vq[i].xr;
      a_if.lkup_index      = vq[i].lk;
      tick();
      check(vq[i].name, obs_a, vq[i].exp);
    end
  endtask

  task automatic clear_b();
    b_if.fill_done_req = 1'b0; b_if.fill_done_index = 3'd0;
    b_if.inv_req = 1'b0; b_if.inv_index = 3'd0; b_if.flash_req = 1'b0;
  endtask

  initial begin
    int seg1;
    // Fill, then inv/fill collision (inv to 5 first, fill to 2 second); reqs held in ack cycle.
    add("fill_acc",    1, 5, 0, 0, 0, 5, mk(1, 0, 0, 1, 5, 1, 0, 1, 8'h00, 0));
    add("fill_done",   0, 0, 0, 0, 0, 5, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h04, 1));
    add("coll_inv",    1, 2, 1, 5, 0, 5, mk(0, 1, 0, 1, 5, 0, 0, 1, 8'h04, 1));
    add("coll_inv_wr", 1, 2, 1, 5, 0, 5, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    add("coll_fill",   1, 2, 0, 0, 0, 2, mk(1, 0, 0, 1, 2, 1, 0, 1, 8'h00, 0));
    add("coll_fill_wr",1, 2, 0, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 1));
    add("coll_idle",   0, 0, 0, 0, 0, 2, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h20, 1));
    seg1 = vq.size();
    // Flash of 3 cycles with a fill to 7 arriving during the flash.
    add("fl_acc",      0, 0, 0, 0, 1, 7, mk(0, 0, 1, 0, 0, 0, 1, 1, 8'h00, 0));
    add("fl_c2",       1, 7, 0, 0, 1, 7, mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0));
    add("fl_c3",       1, 7, 0, 0, 0, 7, mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0));
    add("fl_idle",     1, 7, 0, 0, 0, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    add("fl_fill_acc", 1, 7, 0, 0, 0, 7, mk(1, 0, 0, 1, 7, 1, 0, 1, 8'h00, 0));
    add("fl_fill_wr",  1, 7, 0, 0, 0, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 1));
    add("fl_end",      0, 0, 0, 0, 0, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h01, 1));
    // Flash beats invalidate; invalidate served after flash completes.
    add("pr_flash",    0, 0, 1, 7, 1, 7, mk(0, 0, 1, 0, 0, 0, 1, 1, 8'h00, 0));
    add("pr_c2",       0, 0, 1, 7, 1, 7, mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0));
    add("pr_c3",       0, 0, 1, 7, 0, 7, mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0));
    add("pr_idle",     0, 0, 1, 7, 0, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    add("pr_inv_acc",  0, 0, 1, 7, 0, 7, mk(0, 1, 0, 1, 7, 0, 0, 1, 8'h00, 0));
    add("pr_inv_wr",   0, 0, 1, 7, 0, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
    add("pr_end",      0, 0, 0, 0, 0, 7, mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));

    // Reset for 2 cycles with random requests active.
    rst_a = 1'b1; rst_b = 1'b1;
    for (int c = 0; c < 2; c++) begin
      a_if.fill_done_req = 1'($urandom_range(0, 1)); a_if.fill_done_index = 3'($urandom);
      a_if.inv_req = 1'($urandom_range(0, 1));       a_if.inv_index = 3'($urandom);
      a_if.flash_req = 1'($urandom_range(0, 1));     a_if.lkup_index = 3'($urandom);
      b_if.fill_done_req = 1'($urandom_range(0, 1)); b_if.fill_done_index = 3'($urandom);
      b_if.inv_req = 1'($urandom_range(0, 1));       b_if.inv_index = 3'($urandom);
      b_if.flash_req = 1'($urandom_range(0, 1));     b_if.lkup_index = 3'($urandom);
      tick();
    end
    check("reset_a", obs_a, 19'h0);
    check("reset_b", obs_b, 19'h0);
    a_if.fill_done_req = 1'b0; a_if.inv_req = 1'b0; a_if.flash_req = 1'b0;
    clear_b();
    b_if.lkup_index = 3'd3;
    rst_a = 1'b0; rst_b = 1'b0;

    run_vecs(0, seg1);

    // Fill every index, including index 2 which is already set: write cycle still issued.
    for (int i = 0; i < 8; i++) begin
      a_if.fill_done_req = 1'b1; a_if.fill_done_index = 3'(i);
      tick();
      check($sformatf("fill_all_%0d", i), 19'({a_if.va_wr_cycle, a_if.va_wr_index,
            a_if.va_wr_data}), 19'({1'b1, 3'(i), 1'b1}));
      a_if.fill_done_req = 1'b0;
      tick();
    end
    check("fill_all_vec", 19'(a_if.valid_vec), 19'h0ff);

    run_vecs(seg1, vq.size());

    // Reset during a write cycle suppresses the write.
    b_if.fill_done_req = 1'b1; b_if.fill_done_index = 3'd3;
    tick();
    check("b_fill_acc", obs_b, mk(1, 0, 0, 1, 3, 1, 0, 1, 8'h00, 0));
    rst_b = 1'b1;
    tick();
    check("b_rst_write", obs_b, 19'h0);
    rst_b = 1'b0; clear_b();
    tick();
    check("b_after_rst_w", obs_b, 19'h0);

    // Reset in the 2nd wrFlash cycle of a 4-cycle flash.
    b_if.flash_req = 1'b1;
    tick();
    check("b_fl_c1", obs_b, mk(0, 0, 1, 0, 0, 0, 1, 1, 8'h00, 0));
    b_if.flash_req = 1'b0;
    tick();
    check("b_fl_c2", obs_b, mk(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 0));
    rst_b = 1'b1;
    tick();
    check("b_rst_flash", obs_b, 19'h0);
    rst_b = 1'b0;
    tick();
    check("b_after_rst_f", obs_b, 19'h0);
    tick();
    check("b_after_rst_f2", obs_b, 19'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
